// File: rtl/scard_rx_packet_buffer.sv
// Collects the smartcard receiver byte stream into a single packet buffer, one packet per line gap,
// and holds it for byte-wise host readout along with its length and overflow/dropped flags.
module scard_rx_packet_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_ready,
  input  logic              rx_endofpacket,
  input  logic              rx_idle,
  input  logic              clear,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              pkt_ready,
  output logic [ADDR_W:0]   pkt_len,
  output logic              overflow,
  output logic              dropped,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t              state, nextState;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W:0]     rdPtr;
  logic                idleSeen;
  logic                wrEn;
  logic [ADDR_W-1:0]   wrAddr;
  logic                closePkt;
  logic                rdFire;
  logic                lastRead;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (clear) begin
      nextState = IDLE;
    end else begin
      case (state)
        // A byte arriving with its own end-of-packet strobe forms a complete one-byte packet.
        IDLE:    if (rx_data_ready) nextState = rx_endofpacket ? HOLD : COLLECT;
        COLLECT: if (closePkt) nextState = HOLD;
        HOLD:    if (rdFire && lastRead) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    wrEn     = !clear && rx_data_ready &&
               ((state == IDLE) || ((state == COLLECT) && (pkt_len < FULL)));
    wrAddr   = (state == IDLE) ? '0 : pkt_len[ADDR_W-1:0];
    // Two idle cycles in a row stand in for a missed end-of-packet strobe.
    closePkt = (state == COLLECT) && (rx_endofpacket || (rx_idle && idleSeen));
    rdFire   = !clear && (state == HOLD) && rd_en && (rdPtr < pkt_len);
    lastRead = (rdPtr == (pkt_len - ONE));
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_len   <= '0;
      rdPtr     <= '0;
      pkt_ready <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      idleSeen  <= 1'b0;
    end else if (clear) begin
      pkt_len   <= '0;
      rdPtr     <= '0;
      pkt_ready <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
      rd_valid  <= 1'b0;
      idleSeen  <= 1'b0;
    end else begin
      rd_valid <= rdFire;
      idleSeen <= (state == COLLECT) && rx_idle && !rx_endofpacket;
      if (rdFire) begin
        rd_data <= mem[rdPtr[ADDR_W-1:0]];
        rdPtr   <= rdPtr + ONE;
        if (lastRead) pkt_ready <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rx_data_ready) begin
            pkt_len  <= ONE;
            overflow <= 1'b0;
            if (rx_endofpacket) begin
              pkt_ready <= 1'b1;
              rdPtr     <= '0;
            end
          end
        end
        COLLECT: begin
          if (rx_data_ready) begin
            if (pkt_len < FULL) pkt_len <= pkt_len + ONE;
            else                overflow <= 1'b1;
          end
          if (closePkt) begin
            pkt_ready <= 1'b1;
            rdPtr     <= '0;
          end
        end
        HOLD: begin
          if (rx_data_ready) dropped <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scard_rx_packet_buffer.sv
// Scoreboard bench for scard_rx_packet_buffer: expected bytes are queued as packets are sent
// and compared against every rd_valid strobe.
module tb_scard_rx_packet_buffer;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_data_ready = 1'b0;
  logic              rx_endofpacket = 1'b0;
  logic              rx_idle = 1'b0;
  logic              clear = 1'b0;
  logic              rd_en = 1'b0;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              pkt_ready;
  logic [ADDR_W:0]   pkt_len;
  logic              overflow;
  logic              dropped;
  logic              busy;

  int         nTests = 0;
  int         nFail  = 0;
  int         nValid = 0;
  logic [7:0] expQ[$];
  logic [7:0] expB;
  logic [7:0] d0;
  int         v0;

  scard_rx_packet_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .rx_endofpacket(rx_endofpacket), .rx_idle(rx_idle), .clear(clear), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
    .overflow(overflow), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      nValid++;
      if (expQ.size() == 0) begin
        check("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        expB = expQ.pop_front();
        check("rd_data", {24'd0, rd_data}, {24'd0, expB});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic eop);
    rx_data = b;
    rx_data_ready = 1'b1;
    rx_endofpacket = eop;
    tick();
    rx_data_ready = 1'b0;
    rx_endofpacket = 1'b0;
  endtask

  task automatic endPkt();
    rx_endofpacket = 1'b1;
    tick();
    rx_endofpacket = 1'b0;
  endtask

  task automatic readN(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
    end
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_pkt_ready", pkt_ready, 0);
    check("rst_pkt_len", pkt_len, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_flags", {overflow, dropped}, 0);
    rst_n = 1'b1;
    tick();

    // T1: basic three-byte packet
    sendByte(8'h3B, 1'b0); expQ.push_back(8'h3B);
    sendByte(8'h00, 1'b0); expQ.push_back(8'h00);
    sendByte(8'h12, 1'b0); expQ.push_back(8'h12);
    check("t1_busy_collect", busy, 1);
    check("t1_not_ready_yet", pkt_ready, 0);
    endPkt();
    check("t1_pkt_ready", pkt_ready, 1);
    check("t1_pkt_len", pkt_len, 3);
    readN(3);
    check("t1_ready_after_drain", pkt_ready, 0);
    check("t1_busy_after_drain", busy, 0);
    check("t1_len_kept", pkt_len, 3);
    check("t1_drained", expQ.size(), 0);

    // T2: overflow, only the first DEPTH bytes are kept
    for (int i = 0; i < DEPTH + 2; i++) begin
      sendByte(8'(i), 1'b0);
      if (i < DEPTH) expQ.push_back(8'(i));
    end
    endPkt();
    check("t2_pkt_len_sat", pkt_len, DEPTH);
    check("t2_overflow", overflow, 1);
    check("t2_pkt_ready", pkt_ready, 1);
    readN(DEPTH);
    check("t2_drained", expQ.size(), 0);
    check("t2_overflow_sticky", overflow, 1);

    // T3: byte arriving while a packet is held is dropped
    sendByte(8'hA0, 1'b0); expQ.push_back(8'hA0);
    check("t3_overflow_cleared_new_pkt", overflow, 0);
    sendByte(8'hA1, 1'b0); expQ.push_back(8'hA1);
    endPkt();
    sendByte(8'hFF, 1'b0);
    check("t3_dropped", dropped, 1);
    check("t3_len_unchanged", pkt_len, 2);
    readN(2);
    check("t3_drained", expQ.size(), 0);
    check("t3_dropped_sticky", dropped, 1);
    doClear();
    check("t3_clear_dropped", dropped, 0);
    check("t3_clear_len", pkt_len, 0);
    sendByte(8'hC1, 1'b0);
    sendByte(8'hC2, 1'b0);
    endPkt();
    check("t3_held_before_clear", pkt_ready, 1);
    doClear();
    check("t3_clear_ready", pkt_ready, 0);
    check("t3_clear_busy", busy, 0);
    check("t3_clear_len2", pkt_len, 0);

    // T4: lone end-of-packet ignored; byte with same-cycle end-of-packet
    endPkt();
    tick();
    check("t4_no_empty_pkt", pkt_ready, 0);
    check("t4_idle", busy, 0);
    sendByte(8'h55, 1'b1); expQ.push_back(8'h55);
    check("t4_pkt_ready", pkt_ready, 1);
    check("t4_pkt_len", pkt_len, 1);
    readN(1);
    check("t4_drained", expQ.size(), 0);

    // T5: reset mid-packet discards the partial packet
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    rst_n = 1'b0;
    #2;
    check("t5_async_busy", busy, 0);
    check("t5_async_len", pkt_len, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_no_partial", pkt_ready, 0);
    sendByte(8'h77, 1'b0); expQ.push_back(8'h77);
    endPkt();
    check("t5_pkt_len", pkt_len, 1);
    readN(1);
    check("t5_drained", expQ.size(), 0);

    // T6: reads outside HOLD are ignored
    v0 = nValid;
    d0 = rd_data;
    readN(2);
    check("t6_rd_data_idle", rd_data, d0);
    sendByte(8'h01, 1'b0); expQ.push_back(8'h01);
    readN(1);
    check("t6_rd_data_collect", rd_data, d0);
    endPkt();
    readN(1);
    readN(2);
    check("t6_valid_count", nValid, v0 + 1);
    check("t6_rd_data_kept", rd_data, 8'h01);

    // Safety close after two idle cycles without an end-of-packet strobe
    sendByte(8'h5A, 1'b0); expQ.push_back(8'h5A);
    rx_idle = 1'b1;
    tick();
    check("idle_one_cycle_open", pkt_ready, 0);
    tick();
    rx_idle = 1'b0;
    check("idle_close_ready", pkt_ready, 1);
    check("idle_close_len", pkt_len, 1);
    readN(1);
    check("final_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
